// File: rtl/piso_lr_tx.sv
// Parallel-in serial-out transmitter feeding a 4-bit SIPO_lr deserializer.
// It serializes one bit per clock with selectable MSB-first or LSB-first order.
module piso_lr_tx #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] par_in,
  input  logic             dir_in,
  input  logic             start_valid,
  input  logic             abort,
  output logic             start_ready,
  output logic             load,
  output logic             data_out,
  output logic             dir,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
  localparam bit            HAS_GAP  = (GAP > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [GW-1:0]    gap_cnt_r, gap_cnt_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic             dir_r, dir_s;
  logic             load_r, load_s;
  logic             data_r, data_s;
  logic             ready_r, ready_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    gap_cnt_s = gap_cnt_r;
    shreg_s   = shreg_r;
    dir_s     = dir_r;
    load_s    = 1'b0;
    data_s    = 1'b0;
    ready_s   = 1'b0;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_valid && ready_r) begin
          // The first bit goes out straight from par_in so it appears the cycle after acceptance.
          state_s = ST_SHIFT;
          shreg_s = par_in;
          dir_s   = dir_in;
          cnt_s   = {CW{1'b0}};
          load_s  = 1'b1;
          busy_s  = 1'b1;
          if (dir_in) begin
            data_s = par_in[0];
          end else begin
            data_s = par_in[WIDTH-1];
          end
        end else begin
          ready_s = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_s = ST_IDLE;
          ready_s = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
          done_s = 1'b1;
          if (HAS_GAP) begin
            state_s   = ST_GAP;
            gap_cnt_s = {GW{1'b0}};
            busy_s    = 1'b1;
          end else begin
            state_s = ST_IDLE;
            ready_s = 1'b1;
          end
        end else begin
          cnt_s  = cnt_r + CW'(1);
          load_s = 1'b1;
          busy_s = 1'b1;
          if (dir_r) begin
            shreg_s = {1'b0, shreg_r[WIDTH-1:1]};
            data_s  = shreg_r[1];
          end else begin
            shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
            data_s  = shreg_r[WIDTH-2];
          end
        end
      end
      ST_GAP: begin
        // The done cycle is the first gap cycle, so ready returns GAP cycles after done.
        if (abort || (gap_cnt_r == GAP_LAST)) begin
          state_s = ST_IDLE;
          ready_s = 1'b1;
        end else begin
          gap_cnt_s = gap_cnt_r + GW'(1);
          busy_s    = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        ready_s = 1'b1;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      gap_cnt_r <= {GW{1'b0}};
      shreg_r   <= {WIDTH{1'b0}};
      dir_r     <= 1'b0;
      load_r    <= 1'b0;
      data_r    <= 1'b0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      gap_cnt_r <= gap_cnt_s;
      shreg_r   <= shreg_s;
      dir_r     <= dir_s;
      load_r    <= load_s;
      data_r    <= data_s;
      ready_r   <= ready_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign start_ready = ready_r;
  assign load        = load_r;
  assign data_out    = data_r;
  assign dir         = dir_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_piso_lr_tx.sv
// Self-checking bench for piso_lr_tx: one instance with GAP=1 (d1) and one with GAP=0 (d0).
// Expected bit order comes from the word and direction; a SIPO model rebuilds each word.
module tb_piso_lr_tx;

  localparam int W = 4;

  logic         clock;
  logic         reset;
  logic [W-1:0] par_in;
  logic         dir_in;
  logic         abort;
  logic         sv1, sv0;
  logic         ready1, load1, data1, dir1, busy1, done1;
  logic         ready0, load0, data0, dir0, busy0, done0;

  int checks;
  int errors;

  piso_lr_tx #(.WIDTH(W), .GAP(1)) d1 (
    .clock(clock), .reset(reset), .par_in(par_in), .dir_in(dir_in),
    .start_valid(sv1), .abort(abort), .start_ready(ready1), .load(load1),
    .data_out(data1), .dir(dir1), .busy(busy1), .done(done1)
  );

  piso_lr_tx #(.WIDTH(W), .GAP(0)) d0 (
    .clock(clock), .reset(reset), .par_in(par_in), .dir_in(dir_in),
    .start_valid(sv0), .abort(abort), .start_ready(ready0), .load(load0),
    .data_out(data0), .dir(dir0), .busy(busy0), .done(done0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; par_in = '0; dir_in = 1'b0; abort = 1'b0; sv1 = 1'b0; sv0 = 1'b0;
    #12;
    checks++;
    if ({ready1, load1, data1, dir1, busy1, done1} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_d1 got %b want 100000", {ready1, load1, data1, dir1, busy1, done1});
    end
    checks++;
    if ({ready0, load0, data0, dir0, busy0, done0} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_d0 got %b want 100000", {ready0, load0, data0, dir0, busy0, done0});
    end
    reset = 1'b1;
    tick();
  endtask

  // One full GAP=1 frame on d1; optionally disturbs inputs mid-frame or asserts abort with the start.
  task automatic test_frame(input logic [W-1:0] word, input logic dirv,
                            input bit disturb, input bit abort_at_start);
    logic [W-1:0] sipo;
    logic         eb;
    sipo   = '0;
    par_in = word; dir_in = dirv; sv1 = 1'b1; abort = abort_at_start;
    checks++;
    if (ready1 !== 1'b1) begin
      errors++;
      $display("FAIL frame_ready_pre got %b want 1", ready1);
    end
    tick();
    sv1 = 1'b0; abort = 1'b0;
    for (int k = 0; k < W; k++) begin
      eb = dirv ? word[k] : word[W-1-k];
      checks++;
      if ({load1, data1, dir1, busy1, done1, ready1} !== {1'b1, eb, dirv, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL frame_bit%0d word=%h dir=%b got ld/d/dir/busy/done/rdy=%b want %b",
                 k, word, dirv, {load1, data1, dir1, busy1, done1, ready1},
                 {1'b1, eb, dirv, 1'b1, 1'b0, 1'b0});
      end
      sipo = dirv ? {data1, sipo[W-1:1]} : {sipo[W-2:0], data1};
      if (disturb) begin
        sv1 = (k < W - 1); par_in = ~word; dir_in = ~dirv;
      end
      tick();
    end
    sv1 = 1'b0;
    checks++;
    if ({load1, data1, dir1, busy1, done1, ready1} !== {1'b0, 1'b0, dirv, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL frame_done got %b want %b", {load1, data1, dir1, busy1, done1, ready1},
               {1'b0, 1'b0, dirv, 1'b1, 1'b1, 1'b0});
    end
    checks++;
    if (sipo !== word) begin
      errors++;
      $display("FAIL frame_sipo got %h want %h", sipo, word);
    end
    tick();
    checks++;
    if ({load1, data1, dir1, busy1, done1, ready1} !== {1'b0, 1'b0, dirv, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL frame_idle got %b want %b", {load1, data1, dir1, busy1, done1, ready1},
               {1'b0, 1'b0, dirv, 1'b0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_msb_first();
    test_frame(4'b1011, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_lsb_first();
    test_frame(4'b0001, 1'b1, 1'b0, 1'b0);
  endtask

  // GAP=0: start held high across two words; load pattern 1111 0 1111.
  task automatic test_back_to_back();
    logic [W-1:0] words [2];
    words[0] = 4'hA; words[1] = 4'h5;
    par_in = words[0]; dir_in = 1'b0; sv0 = 1'b1;
    checks++;
    if (ready0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_pre got %b want 1", ready0);
    end
    tick();
    par_in = words[1];
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < W; k++) begin
        checks++;
        if ({load0, data0, busy0, done0} !== {1'b1, words[f][W-1-k], 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL b2b_f%0d_bit%0d got %b want %b", f, k, {load0, data0, busy0, done0},
                   {1'b1, words[f][W-1-k], 1'b1, 1'b0});
        end
        tick();
      end
      checks++;
      if ({load0, data0, busy0, done0, ready0} !== 5'b00011) begin
        errors++;
        $display("FAIL b2b_f%0d_done got %b want 00011", f, {load0, data0, busy0, done0, ready0});
      end
      if (f == 1) sv0 = 1'b0;
      tick();
      if (f == 0) sv0 = 1'b0;
    end
    checks++;
    if ({load0, done0, ready0} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_end got %b want 001", {load0, done0, ready0});
    end
  endtask

  task automatic test_abort();
    par_in = 4'hF; dir_in = 1'b1; sv1 = 1'b1;
    tick();
    sv1 = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({load1, data1, dir1, busy1, done1, ready1} !== 6'b001001) begin
      errors++;
      $display("FAIL abort_edge got %b want 001001", {load1, data1, dir1, busy1, done1, ready1});
    end
    tick();
    checks++;
    if ({load1, done1, ready1} !== 3'b001) begin
      errors++;
      $display("FAIL abort_after got %b want 001", {load1, done1, ready1});
    end
    test_frame(4'h3, 1'b0, 1'b0, 1'b0);
    test_frame(4'h6, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    par_in = 4'b1110; dir_in = 1'b1; sv1 = 1'b1;
    tick();
    sv1 = 1'b0;
    tick();
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({load1, data1, dir1, busy1, done1, ready1} !== 6'b000001) begin
      errors++;
      $display("FAIL async_reset got %b want 000001", {load1, data1, dir1, busy1, done1, ready1});
    end
    #2;
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if ({load1, data1, busy1, done1, ready1} !== 5'b00001) begin
        errors++;
        $display("FAIL post_reset_c%0d got %b want 00001", c, {load1, data1, busy1, done1, ready1});
      end
    end
  endtask

  task automatic test_ignore_busy();
    test_frame(4'b1001, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({load1, busy1, ready1} !== 3'b001) begin
        errors++;
        $display("FAIL ignore_c%0d got %b want 001", c, {load1, busy1, ready1});
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      test_frame(W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_ignore_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
